// File: rtl/pwm_trip_zone_pkg.sv
// Shared types, widths and helpers for the PWM trip-zone protection stage.

`ifndef PWM_WIDTH
`define PWM_WIDTH 8
`endif
`ifndef FLT_WIDTH
`define FLT_WIDTH 4
`endif
`ifndef FILT_WIDTH
`define FILT_WIDTH 8
`endif
`ifndef HOLD_WIDTH
`define HOLD_WIDTH 16
`endif

package pwm_trip_zone_pkg;

    // Channel count of the upstream carrier core and default widths.
    localparam int PWM_WIDTH  = `PWM_WIDTH;
    localparam int FLT_WIDTH  = `FLT_WIDTH;
    localparam int FILT_WIDTH = `FILT_WIDTH;
    localparam int HOLD_WIDTH = `HOLD_WIDTH;

    // Depth of the fault-pin synchroniser.
    localparam int SYNC_STAGES = 2;

    // Protection state. WAIT_SYNC is the reset state so the pins stay at
    // their safe level until the carrier reaches a clean boundary.
    typedef enum logic [1:0] {
        TZ_RUN       = 2'd0,
        TZ_TRIP      = 2'd1,
        TZ_HOLD      = 2'd2,
        TZ_WAIT_SYNC = 2'd3
    } tz_trip_state_e;

    // Every state other than RUN holds the outputs at their safe level.
    function automatic logic tz_is_safe(input tz_trip_state_e s);
        return (s != TZ_RUN);
    endfunction

endpackage : pwm_trip_zone_pkg

// File: rtl/pwm_trip_zone_fault_filter.sv
// One external fault input: metastability synchroniser, polarity and
// enable gating, then a saturating glitch-filter counter.

module pwm_trip_zone_fault_filter
    import pwm_trip_zone_pkg::*;
#(
    parameter int FILT_W = FILT_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fault_in,
    input  logic              fault_en,
    input  logic              fault_pol,
    input  logic [FILT_W-1:0] filt_len,
    output logic              qual
);

    // Pin synchroniser; index 0 is the stage that sees the raw pin.
    logic [SYNC_STAGES-1:0] sync_q;
    // Enable and polarity travel alongside the synchroniser so that a
    // configuration change reaches the counter with the same latency as a
    // pin edge and the two can never be misaligned by a cycle.
    logic [SYNC_STAGES-1:0] en_q;
    logic [SYNC_STAGES-1:0] pol_q;

    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_d;
    logic              raw;
    logic              at_len;

    // Shift the pin and its configuration through the synchroniser stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            en_q   <= '0;
            pol_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fault_in};
            en_q   <= {en_q[SYNC_STAGES-2:0], fault_en};
            pol_q  <= {pol_q[SYNC_STAGES-2:0], fault_pol};
        end
    end

    // pol = 1 means the pin is active-high; a disabled input never asserts.
    assign raw    = en_q[SYNC_STAGES-1] & ~(sync_q[SYNC_STAGES-1] ^ pol_q[SYNC_STAGES-1]);

    // Greater-or-equal keeps the counter saturated even if software shrinks
    // filt_len while a fault is already being counted.
    assign at_len = (cnt_q >= filt_len);

    // With filt_len = 0 at_len is always true, so qual degenerates to raw.
    assign qual   = raw & at_len;

    // Count consecutive active cycles, saturate at filt_len, drop on any gap.
    always_comb begin
        cnt_d = cnt_q;
        if (!raw) begin
            cnt_d = '0;
        end else if (at_len) begin
            cnt_d = filt_len;
        end else begin
            cnt_d = cnt_q + FILT_W'(1);
        end
    end

    // Filter counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : pwm_trip_zone_fault_filter

// File: rtl/pwm_trip_zone.sv
// Trip-zone protection between the PWM core and the gate-driver pins.
// Qualified faults latch a trip that forces every output to a programmable
// safe level; release needs a clear, a minimum hold time and a carrier sync.

module pwm_trip_zone
    import pwm_trip_zone_pkg::*;
#(
    parameter int N_CH   = PWM_WIDTH,
    parameter int N_FLT  = FLT_WIDTH,
    parameter int FILT_W = FILT_WIDTH,
    parameter int HOLD_W = HOLD_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   pwmin_A,
    input  logic [N_CH-1:0]   pwmin_B,
    input  logic [N_CH-1:0]   sync_event,
    input  logic [N_FLT-1:0]  fault_in,
    input  logic [N_FLT-1:0]  fault_en,
    input  logic [N_FLT-1:0]  fault_pol,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [HOLD_W-1:0] hold_time,
    input  logic [N_CH-1:0]   safe_A,
    input  logic [N_CH-1:0]   safe_B,
    input  logic              clear,
    input  logic              auto_clear,
    output logic [N_CH-1:0]   pwmout_A,
    output logic [N_CH-1:0]   pwmout_B,
    output logic              tripped,
    output logic [N_FLT-1:0]  fault_latched,
    output logic              trip_irq
);

    logic [N_FLT-1:0]  qual;
    logic              any_qual;
    logic              resume_sync;
    logic              clear_req;

    tz_trip_state_e    state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              tripped_q;
    logic              trip_irq_q;
    logic [N_FLT-1:0]  fault_latched_q;
    logic [N_CH-1:0]   pwmout_a_q;
    logic [N_CH-1:0]   pwmout_b_q;

    // One glitch filter per external fault input.
    generate
        for (genvar gi = 0; gi < N_FLT; gi++) begin : g_flt
            pwm_trip_zone_fault_filter #(
                .FILT_W   (FILT_W)
            ) u_filter (
                .clk      (clk),
                .reset    (reset),
                .fault_in (fault_in[gi]),
                .fault_en (fault_en[gi]),
                .fault_pol(fault_pol[gi]),
                .filt_len (filt_len),
                .qual     (qual[gi])
            );
        end
    endgenerate

    assign any_qual    = |qual;
    assign resume_sync = |sync_event;
    // auto_clear behaves as a clear that is permanently requested; whether
    // it is honoured still depends on no fault being qualified.
    assign clear_req   = clear | auto_clear;

    // Protection state machine with its hold counter, sticky fault record
    // and trip interrupt; a qualified fault wins over every other condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= TZ_WAIT_SYNC;
            hold_cnt_q      <= '0;
            tripped_q       <= 1'b1;
            trip_irq_q      <= 1'b0;
            fault_latched_q <= '0;
        end else begin
            trip_irq_q      <= 1'b0;
            fault_latched_q <= fault_latched_q | qual;
            case (state_q)
                TZ_RUN: begin
                    if (any_qual) begin
                        state_q    <= TZ_TRIP;
                        tripped_q  <= 1'b1;
                        trip_irq_q <= 1'b1;
                    end
                end
                TZ_TRIP: begin
                    // A clear that arrives while a fault is still qualified
                    // is dropped rather than remembered.
                    if (!any_qual && clear_req) begin
                        state_q         <= TZ_HOLD;
                        hold_cnt_q      <= hold_time;
                        fault_latched_q <= '0;
                    end
                end
                TZ_HOLD: begin
                    if (any_qual) begin
                        state_q    <= TZ_TRIP;
                        trip_irq_q <= 1'b1;
                    end else if (hold_cnt_q == '0) begin
                        state_q <= TZ_WAIT_SYNC;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end
                end
                TZ_WAIT_SYNC: begin
                    if (any_qual) begin
                        state_q    <= TZ_TRIP;
                        trip_irq_q <= 1'b1;
                    end else if (resume_sync) begin
                        state_q   <= TZ_RUN;
                        tripped_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= TZ_TRIP;
                    tripped_q <= 1'b1;
                end
            endcase
        end
    end

    // Output stage: pass the core's pulses only while running, otherwise
    // drive the safe levels; decided from the current state, one cycle late.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwmout_a_q <= '0;
            pwmout_b_q <= '0;
        end else if (tz_is_safe(state_q)) begin
            pwmout_a_q <= safe_A;
            pwmout_b_q <= safe_B;
        end else begin
            pwmout_a_q <= pwmin_A;
            pwmout_b_q <= pwmin_B;
        end
    end

    assign pwmout_A      = pwmout_a_q;
    assign pwmout_B      = pwmout_b_q;
    assign tripped       = tripped_q;
    assign fault_latched = fault_latched_q;
    assign trip_irq      = trip_irq_q;

endmodule : pwm_trip_zone

// File: tb/tb_pwm_trip_zone.sv
// Directed bench for the PWM trip-zone stage with hand-computed expectations.

module tb_pwm_trip_zone;

    localparam int N_CH   = 8;
    localparam int N_FLT  = 4;
    localparam int FILT_W = 8;
    localparam int HOLD_W = 16;

    logic              clk;
    logic              reset;
    logic [N_CH-1:0]   pwmin_A;
    logic [N_CH-1:0]   pwmin_B;
    logic [N_CH-1:0]   sync_event;
    logic [N_FLT-1:0]  fault_in;
    logic [N_FLT-1:0]  fault_en;
    logic [N_FLT-1:0]  fault_pol;
    logic [FILT_W-1:0] filt_len;
    logic [HOLD_W-1:0] hold_time;
    logic [N_CH-1:0]   safe_A;
    logic [N_CH-1:0]   safe_B;
    logic              clear;
    logic              auto_clear;
    logic [N_CH-1:0]   pwmout_A;
    logic [N_CH-1:0]   pwmout_B;
    logic              tripped;
    logic [N_FLT-1:0]  fault_latched;
    logic              trip_irq;

    int checks;
    int errors;
    int irq_cnt;
    int irq_base;

    pwm_trip_zone #(
        .N_CH         (N_CH),
        .N_FLT        (N_FLT),
        .FILT_W       (FILT_W),
        .HOLD_W       (HOLD_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pwmin_A      (pwmin_A),
        .pwmin_B      (pwmin_B),
        .sync_event   (sync_event),
        .fault_in     (fault_in),
        .fault_en     (fault_en),
        .fault_pol    (fault_pol),
        .filt_len     (filt_len),
        .hold_time    (hold_time),
        .safe_A       (safe_A),
        .safe_B       (safe_B),
        .clear        (clear),
        .auto_clear   (auto_clear),
        .pwmout_A     (pwmout_A),
        .pwmout_B     (pwmout_B),
        .tripped      (tripped),
        .fault_latched(fault_latched),
        .trip_irq     (trip_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %-18s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %-18s 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (trip_irq === 1'b1) irq_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold one fault pin in its active-high level for len sampled cycles.
    task automatic pulse_fault(input int idx, input int len);
        fault_in[idx] = 1'b1;
        ticks(len);
        fault_in[idx] = 1'b0;
    endtask

    // From TRIP with no fault qualified: clear, ride out the hold time with a
    // sync request pending, and confirm RUN resumes exactly one cycle after.
    task automatic hold_resume(input int hold_cycles);
        clear      = 1'b1;
        sync_event = 8'h01;
        tick();
        clear = 1'b0;
        check("hold_latch_clr", 32'(fault_latched), 32'h0);
        ticks(hold_cycles + 1);
        check("hold_still_trip", 32'(tripped), 32'h1);
        tick();
        check("hold_resume_run", 32'(tripped), 32'h0);
        sync_event = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog tripped=%0b exp=finish", tripped);
        $fatal(1);
    end

    initial begin
        checks     = 0;
        errors     = 0;
        irq_cnt    = 0;
        reset      = 1'b1;
        pwmin_A    = 8'h5A;
        pwmin_B    = 8'hA5;
        sync_event = '0;
        fault_in   = '0;
        fault_en   = 4'b1011;
        fault_pol  = 4'b1011;
        filt_len   = 8'd3;
        hold_time  = 16'd10;
        safe_A     = 8'h00;
        safe_B     = 8'h3C;
        clear      = 1'b0;
        auto_clear = 1'b0;

        // Reset values.
        ticks(3);
        check("rst_pwmout_A", 32'(pwmout_A), 32'h0);
        check("rst_pwmout_B", 32'(pwmout_B), 32'h0);
        check("rst_tripped", 32'(tripped), 32'h1);
        check("rst_latched", 32'(fault_latched), 32'h0);
        check("rst_irq", 32'(trip_irq), 32'h0);

        // Outputs go safe immediately, RUN only after a carrier sync.
        reset = 1'b0;
        tick();
        check("safe_after_rst_A", 32'(pwmout_A), 32'h00);
        check("safe_after_rst_B", 32'(pwmout_B), 32'h3C);
        ticks(2);
        sync_event = 8'h08;
        tick();
        sync_event = '0;
        check("sync_to_run", 32'(tripped), 32'h0);
        check("run_first_safe", 32'(pwmout_A), 32'h00);
        tick();
        check("run_pass_A", 32'(pwmout_A), 32'h5A);
        check("run_pass_B", 32'(pwmout_B), 32'hA5);
        pwmin_A = 8'hC3;
        tick();
        check("run_lag_A", 32'(pwmout_A), 32'hC3);

        // Safe levels are ignored while running.
        safe_A = 8'hAA;
        safe_B = 8'h55;
        tick();
        check("run_ignores_safe", 32'(pwmout_A), 32'hC3);

        // A 3-cycle pulse with filt_len = 3 is a glitch.
        pulse_fault(1, 3);
        ticks(8);
        check("short_no_trip", 32'(tripped), 32'h0);
        check("short_no_latch", 32'(fault_latched), 32'h0);

        // A 4-cycle pulse trips: state at +6, pins forced at +7.
        pulse_fault(1, 4);
        tick();
        check("trip_not_yet", 32'(tripped), 32'h0);
        tick();
        check("trip_state", 32'(tripped), 32'h1);
        check("trip_irq_pulse", 32'(trip_irq), 32'h1);
        check("trip_latched", 32'(fault_latched), 32'h2);
        check("trip_out_still_run", 32'(pwmout_A), 32'hC3);
        tick();
        check("trip_forced_A", 32'(pwmout_A), 32'hAA);
        check("trip_forced_B", 32'(pwmout_B), 32'h55);
        check("trip_irq_single", 32'(trip_irq), 32'h0);

        // Clear while the fault is still qualified is dropped.
        ticks(2);
        fault_in[1] = 1'b1;
        ticks(6);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ticks(2);
        check("clr_ignored_latch", 32'(fault_latched), 32'h2);
        check("clr_ignored_trip", 32'(tripped), 32'h1);
        check("irq_no_reentry", 32'(irq_cnt), 32'd1);

        // Fault removed, clear accepted: 11 cycles of HOLD, then sync.
        fault_in[1] = 1'b0;
        ticks(3);
        hold_resume(10);

        // Re-trip from HOLD when hold_cnt reaches 5.
        pulse_fault(0, 4);
        ticks(4);
        check("trip2_latched", 32'(fault_latched), 32'h1);
        clear = 1'b1;
        tick();
        clear       = 1'b0;
        fault_in[0] = 1'b1;
        irq_base    = irq_cnt;
        ticks(4);
        fault_in[0] = 1'b0;
        tick();
        check("hold_no_irq_yet", 32'(irq_cnt - irq_base), 32'd0);
        tick();
        check("hold_retrip_irq", 32'(trip_irq), 32'h1);
        check("hold_retrip_latch", 32'(fault_latched), 32'h1);
        ticks(3);
        hold_resume(10);

        // WAIT_SYNC with sync and a qualified fault together: TRIP wins.
        hold_time = 16'd0;
        pulse_fault(3, 4);
        ticks(4);
        fault_in[3] = 1'b1;
        ticks(3);
        clear = 1'b1;
        tick();
        clear       = 1'b0;
        fault_in[3] = 1'b0;
        tick();
        sync_event = 8'h02;
        irq_base   = irq_cnt;
        tick();
        sync_event = '0;
        check("ws_trip_wins", 32'(tripped), 32'h1);
        check("ws_trip_irq", 32'(irq_cnt - irq_base), 32'd1);
        check("ws_latched", 32'(fault_latched), 32'h8);
        tick();
        check("ws_out_safe", 32'(pwmout_A), 32'hAA);
        ticks(3);
        hold_resume(0);

        // Active-low input 2, disabled with the pin low: no trip.
        ticks(10);
        check("en_off_no_trip", 32'(tripped), 32'h0);
        fault_en[2] = 1'b1;
        ticks(5);
        check("en_on_not_yet", 32'(tripped), 32'h0);
        tick();
        check("en_on_trip", 32'(tripped), 32'h1);
        tick();
        check("en_on_forced", 32'(pwmout_A), 32'hAA);

        // auto_clear releases once the active-low pin returns high.
        auto_clear = 1'b1;
        ticks(3);
        check("auto_fault_held", 32'(tripped), 32'h1);
        check("auto_latch_b2", 32'(fault_latched), 32'h4);
        fault_in[2] = 1'b1;
        ticks(3);
        check("auto_latch_clr", 32'(fault_latched), 32'h0);
        ticks(4);
        check("auto_wait_sync", 32'(tripped), 32'h1);
        sync_event = 8'h80;
        tick();
        sync_event = '0;
        check("auto_resume", 32'(tripped), 32'h0);
        pwmin_A = 8'h3E;
        tick();
        check("auto_pass_A", 32'(pwmout_A), 32'h3E);
        auto_clear = 1'b0;

        // Reset in the middle of HOLD discards the hold count.
        hold_time = 16'd10;
        pulse_fault(1, 4);
        ticks(4);
        check("rst_test_trip", 32'(tripped), 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ticks(2);
        reset = 1'b1;
        tick();
        check("midhold_rst_A", 32'(pwmout_A), 32'h0);
        check("midhold_rst_latch", 32'(fault_latched), 32'h0);
        check("midhold_rst_trip", 32'(tripped), 32'h1);
        reset      = 1'b0;
        sync_event = 8'h01;
        tick();
        sync_event = '0;
        check("midhold_rst_run", 32'(tripped), 32'h0);
        check("midhold_rst_safeB", 32'(pwmout_B), 32'h55);

        check("irq_total", 32'(irq_cnt), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pwm_trip_zone
